// File: rtl/spi_cmd_pkg.sv
// -----------------------------------------------------------------------------
// spi_cmd_pkg
// Shared constants and types for the SPI command framer:
//   - SYNC_RX / SYNC_TX : frame header sync byte and status word sync byte
//   - ST_*              : 3-bit frame status codes
//   - frame_state_e     : frame parser states
//   - status_word()     : builds the 16-bit status word returned toward TX
// -----------------------------------------------------------------------------
package spi_cmd_pkg;

   localparam logic [7:0] SYNC_RX = 8'hA5;
   localparam logic [7:0] SYNC_TX = 8'h5A;

   localparam logic [2:0] ST_OK       = 3'd0;
   localparam logic [2:0] ST_BAD_SYNC = 3'd1;
   localparam logic [2:0] ST_BAD_CSUM = 3'd2;
   localparam logic [2:0] ST_OVERFLOW = 3'd3;
   localparam logic [2:0] ST_CS_ABORT = 3'd4;
   localparam logic [2:0] ST_TIMEOUT  = 3'd5;
   localparam logic [2:0] ST_RX_ERR   = 3'd6;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PAYLOAD = 2'd1,
      S_CHECK   = 2'd2,
      S_DISCARD = 2'd3
   } frame_state_e;

   function automatic logic [15:0] status_word(input logic [3:0] opcode,
                                               input logic [2:0] status);
      return {SYNC_TX, opcode, 1'b0, status};
   endfunction

endpackage

// File: rtl/spi_commit_fifo.sv
// -----------------------------------------------------------------------------
// spi_commit_fifo
// Three-pointer FIFO. Writes land at the write pointer but stay invisible to
// the reader until i_commit copies the write pointer into the commit pointer.
// i_rewind discards everything written since the last commit. The read side
// is a registered output stage that only presents committed entries.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_wr_en, i_wr_data      write one entry at the write pointer
//   i_commit                commit pointer <- write pointer
//   i_rewind                write pointer <- commit pointer
//   o_rd_data, o_rd_valid   registered head entry (committed only)
//   i_rd_ready              reader accepts the head entry
//   o_level                 write pointer minus read pointer (committed +
//                           uncommitted, including the presented entry)
// -----------------------------------------------------------------------------
module spi_commit_fifo
   import spi_cmd_pkg::*;
#(
   parameter int unsigned WIDTH = 21,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_wr_en,
   input  logic [WIDTH-1:0]         i_wr_data,
   input  logic                     i_commit,
   input  logic                     i_rewind,
   output logic [WIDTH-1:0]         o_rd_data,
   output logic                     o_rd_valid,
   input  logic                     i_rd_ready,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0]       wr_q, wr_d;
   logic [AW:0]       cm_q, cm_d;
   logic [AW:0]       rd_q, rd_d;
   logic [WIDTH-1:0]  out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;
   logic              pop;
   logic              committed_empty;
   logic [WIDTH-1:0]  mem_q [DEPTH];

   // Empty when both pointers are on the same lap (MSB equal) and at the
   // same slot; the extra MSB is what tells full from empty.
   function automatic logic ptr_empty(input logic [AW:0] a, input logic [AW:0] b);
      return (a[AW] == b[AW]) && (a[AW-1:0] == b[AW-1:0]);
   endfunction

   always_comb begin
      pop             = out_valid_q && i_rd_ready;
      rd_d            = pop ? (rd_q + PTR_ONE) : rd_q;
      cm_d            = i_commit ? wr_q : cm_q;
      wr_d            = wr_q;
      if (i_rewind) begin
         wr_d = cm_q;
      end else if (i_wr_en) begin
         wr_d = wr_q + PTR_ONE;
      end
      // The output stage looks at the already-committed pointer, so a commit
      // becomes visible one cycle after the commit strobe.
      committed_empty = ptr_empty(cm_q, rd_d);
      out_valid_d     = !committed_empty;
      // Reloading the same slot while stalled keeps the data stable.
      out_data_d      = mem_q[rd_d[AW-1:0]];
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_q        <= '0;
         cm_q        <= '0;
         rd_q        <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         wr_q        <= wr_d;
         cm_q        <= cm_d;
         rd_q        <= rd_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         mem_q[wr_q[AW-1:0]] <= i_wr_data;
      end
   end

   assign o_rd_data  = out_data_q;
   assign o_rd_valid = out_valid_q;
   assign o_level    = wr_q - rd_q;

endmodule

// File: rtl/spi_cmd_framer.sv
// -----------------------------------------------------------------------------
// spi_cmd_framer
// Parses the 16-bit RX word stream into command frames:
//   header {A5, opcode, len}, len payload words, checksum (XOR of all words).
// Payload is staged in spi_commit_fifo and released only once the checksum
// matches. Each frame produces one status word {5A, opcode, 0, status}.
//
// Optional feature: define SPI_CMD_FRAMER_TIMEOUT_EN to build an inter-word
// timeout counter (TIMEOUT_CYCLES) that aborts a stalled frame with TIMEOUT.
//
// Ports:
//   i_sys_clk, i_sys_rst_n              clock, asynchronous active-low reset
//   i_rx_data, i_rx_valid, i_rx_error   RX word stream from the buffer manager
//   i_spi_cs_n                          synchronised chip select
//   o_pl_data/opcode/last/valid,
//   i_pl_ready                          committed payload stream
//   o_tx_data, o_tx_valid, i_tx_ready   status word handshake
//   o_frame_done, o_frame_status        per-frame end pulse and status code
//   o_fifo_level                        committed + uncommitted FIFO entries
// -----------------------------------------------------------------------------
module spi_cmd_framer
   import spi_cmd_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 16,
   parameter int unsigned FIFO_DEPTH     = 16,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic                          i_sys_clk,
   input  logic                          i_sys_rst_n,
   input  logic [DATA_WIDTH-1:0]         i_rx_data,
   input  logic                          i_rx_valid,
   input  logic                          i_rx_error,
   input  logic                          i_spi_cs_n,
   output logic [DATA_WIDTH-1:0]         o_pl_data,
   output logic [3:0]                    o_pl_opcode,
   output logic                          o_pl_last,
   output logic                          o_pl_valid,
   input  logic                          i_pl_ready,
   output logic [DATA_WIDTH-1:0]         o_tx_data,
   output logic                          o_tx_valid,
   input  logic                          i_tx_ready,
   output logic                          o_frame_done,
   output logic [2:0]                    o_frame_status,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

   localparam int unsigned LVL_W   = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned ENTRY_W = DATA_WIDTH + 5;
   localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);

   if (DATA_WIDTH != 16 || FIFO_DEPTH < 16 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
      $error("spi_cmd_framer: unsupported parameter set");
   end

   frame_state_e          state_q, state_d;
   logic [3:0]            opcode_q, opcode_d;
   logic [3:0]            len_q, len_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] xor_q, xor_d;
   logic                  cs_prev_q, cs_prev_d;
   logic                  done_q, done_d;
   logic [2:0]            frame_status_q, frame_status_d;
   logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
   logic                  tx_valid_q, tx_valid_d;

   logic                  fifo_wr_en;
   logic [ENTRY_W-1:0]    fifo_wr_data;
   logic                  fifo_commit;
   logic                  fifo_rewind;
   logic [ENTRY_W-1:0]    fifo_rd_data;
   logic [LVL_W-1:0]      fifo_level;

   logic                  cs_rise;
   logic                  pl_last;
   logic [LVL_W-1:0]      free_entries;
   logic [7:0]            hdr_sync;
   logic [3:0]            hdr_opcode;
   logic [3:0]            hdr_len;
   logic                  end_frame;
   logic [2:0]            end_code;
   logic [3:0]            end_opcode;
   logic                  timeout_hit;

`ifdef SPI_CMD_FRAMER_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [TMO_W-1:0] TMO_ONE = {{(TMO_W-1){1'b0}}, 1'b1};
   localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES - 1);

   logic [TMO_W-1:0] tmo_q, tmo_d;

   // Counts idle cycles since the last word while a frame is open.
   always_comb begin
      tmo_d       = tmo_q;
      timeout_hit = 1'b0;
      if (state_q == S_IDLE || i_rx_valid) begin
         tmo_d = '0;
      end else begin
         tmo_d       = tmo_q + TMO_ONE;
         timeout_hit = (tmo_q == TMO_MAX);
      end
   end

   always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
      if (!i_sys_rst_n) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d        = state_q;
      opcode_d       = opcode_q;
      len_d          = len_q;
      cnt_d          = cnt_q;
      xor_d          = xor_q;
      cs_prev_d      = i_spi_cs_n;
      done_d         = 1'b0;
      frame_status_d = frame_status_q;
      tx_data_d      = tx_data_q;
      tx_valid_d     = tx_valid_q && !i_tx_ready;

      hdr_sync       = i_rx_data[15:8];
      hdr_opcode     = i_rx_data[7:4];
      hdr_len        = i_rx_data[3:0];
      cs_rise        = i_spi_cs_n && !cs_prev_q;
      free_entries   = DEPTH_L - fifo_level;
      pl_last        = (cnt_q == (len_q - 4'd1));

      fifo_wr_en     = 1'b0;
      fifo_wr_data   = {pl_last, opcode_q, i_rx_data};
      fifo_commit    = 1'b0;
      fifo_rewind    = 1'b0;

      end_frame      = 1'b0;
      end_code       = ST_OK;
      end_opcode     = opcode_q;

      if (state_q != S_IDLE && i_rx_error) begin
         end_frame   = 1'b1;
         end_code    = ST_RX_ERR;
         fifo_rewind = 1'b1;
      end else if (state_q != S_IDLE && cs_rise) begin
         // Abort beats a checksum word arriving in the same cycle.
         end_frame   = 1'b1;
         end_code    = ST_CS_ABORT;
         fifo_rewind = 1'b1;
      end else if (timeout_hit) begin
         end_frame   = 1'b1;
         end_code    = ST_TIMEOUT;
         fifo_rewind = 1'b1;
      end else if (i_rx_valid) begin
         unique case (state_q)
            S_IDLE: begin
               if (hdr_sync != SYNC_RX) begin
                  end_frame  = 1'b1;
                  end_code   = ST_BAD_SYNC;
                  end_opcode = 4'd0;
               end else begin
                  opcode_d = hdr_opcode;
                  len_d    = hdr_len;
                  cnt_d    = 4'd0;
                  xor_d    = i_rx_data;
                  if ({{(LVL_W-4){1'b0}}, hdr_len} > free_entries) begin
                     state_d = S_DISCARD;
                  end else if (hdr_len == 4'd0) begin
                     state_d = S_CHECK;
                  end else begin
                     state_d = S_PAYLOAD;
                  end
               end
            end
            S_PAYLOAD: begin
               fifo_wr_en = 1'b1;
               xor_d      = xor_q ^ i_rx_data;
               cnt_d      = cnt_q + 4'd1;
               if (pl_last) begin
                  state_d = S_CHECK;
               end
            end
            S_CHECK: begin
               end_frame = 1'b1;
               if (i_rx_data == xor_q) begin
                  fifo_commit = 1'b1;
                  end_code    = ST_OK;
               end else begin
                  fifo_rewind = 1'b1;
                  end_code    = ST_BAD_CSUM;
               end
            end
            S_DISCARD: begin
               // len payload words plus the checksum: the (len+1)-th word
               // is the one seen with cnt == len.
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == len_q) begin
                  end_frame = 1'b1;
                  end_code  = ST_OVERFLOW;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      if (end_frame) begin
         state_d        = S_IDLE;
         done_d         = 1'b1;
         frame_status_d = end_code;
         tx_data_d      = status_word(end_opcode, end_code);
         tx_valid_d     = 1'b1;
      end
   end

   always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
      if (!i_sys_rst_n) begin
         state_q        <= S_IDLE;
         opcode_q       <= '0;
         len_q          <= '0;
         cnt_q          <= '0;
         xor_q          <= '0;
         cs_prev_q      <= 1'b1;
         done_q         <= 1'b0;
         frame_status_q <= '0;
         tx_data_q      <= '0;
         tx_valid_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         opcode_q       <= opcode_d;
         len_q          <= len_d;
         cnt_q          <= cnt_d;
         xor_q          <= xor_d;
         cs_prev_q      <= cs_prev_d;
         done_q         <= done_d;
         frame_status_q <= frame_status_d;
         tx_data_q      <= tx_data_d;
         tx_valid_q     <= tx_valid_d;
      end
   end

   spi_commit_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk      (i_sys_clk),
      .i_rst_n    (i_sys_rst_n),
      .i_wr_en    (fifo_wr_en),
      .i_wr_data  (fifo_wr_data),
      .i_commit   (fifo_commit),
      .i_rewind   (fifo_rewind),
      .o_rd_data  (fifo_rd_data),
      .o_rd_valid (o_pl_valid),
      .i_rd_ready (i_pl_ready),
      .o_level    (fifo_level)
   );

   assign o_pl_last      = fifo_rd_data[ENTRY_W-1];
   assign o_pl_opcode    = fifo_rd_data[ENTRY_W-2:DATA_WIDTH];
   assign o_pl_data      = fifo_rd_data[DATA_WIDTH-1:0];
   assign o_tx_data      = tx_data_q;
   assign o_tx_valid     = tx_valid_q;
   assign o_frame_done   = done_q;
   assign o_frame_status = frame_status_q;
   assign o_fifo_level   = fifo_level;

endmodule

// File: tb/tb_spi_cmd_framer.sv
// -----------------------------------------------------------------------------
// tb_spi_cmd_framer
// Directed frames with hand-computed payload and status words. Expected
// payload entries {last, opcode, data} and status entries {code, tx_word}
// are queued as stimulus is issued; a monitor pops them as the DUT emits.
// -----------------------------------------------------------------------------
module tb_spi_cmd_framer;

   logic        clk;
   logic        rst_n;
   logic [15:0] i_rx_data;
   logic        i_rx_valid;
   logic        i_rx_error;
   logic        i_spi_cs_n;
   logic [15:0] o_pl_data;
   logic [3:0]  o_pl_opcode;
   logic        o_pl_last;
   logic        o_pl_valid;
   logic        i_pl_ready;
   logic [15:0] o_tx_data;
   logic        o_tx_valid;
   logic        i_tx_ready;
   logic        o_frame_done;
   logic [2:0]  o_frame_status;
   logic [4:0]  o_fifo_level;

   int n_checks = 0;
   int n_fail   = 0;

   logic [20:0] exp_pl_q[$];
   logic [18:0] exp_sts_q[$];

   spi_cmd_framer dut (
      .i_sys_clk      (clk),
      .i_sys_rst_n    (rst_n),
      .i_rx_data      (i_rx_data),
      .i_rx_valid     (i_rx_valid),
      .i_rx_error     (i_rx_error),
      .i_spi_cs_n     (i_spi_cs_n),
      .o_pl_data      (o_pl_data),
      .o_pl_opcode    (o_pl_opcode),
      .o_pl_last      (o_pl_last),
      .o_pl_valid     (o_pl_valid),
      .i_pl_ready     (i_pl_ready),
      .o_tx_data      (o_tx_data),
      .o_tx_valid     (o_tx_valid),
      .i_tx_ready     (i_tx_ready),
      .o_frame_done   (o_frame_done),
      .o_frame_status (o_frame_status),
      .o_fifo_level   (o_fifo_level)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called at posedge+1; the word is sampled at the next edge.
   task automatic send_word(input logic [15:0] w);
      i_rx_data  = w;
      i_rx_valid = 1'b1;
      @(posedge clk);
      #1;
      i_rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic exp_pl(input logic last, input logic [3:0] op, input logic [15:0] d);
      exp_pl_q.push_back({last, op, d});
   endtask

   task automatic exp_sts(input logic [2:0] code, input logic [15:0] tx);
      exp_sts_q.push_back({code, tx});
   endtask

   // ---------------- scoreboard monitor ----------------
   initial begin
      logic [20:0] e_pl;
      logic [18:0] e_st;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (o_pl_valid && i_pl_ready) begin
               if (exp_pl_q.size() == 0) begin
                  check("pl_unexpected", {11'd0, o_pl_last, o_pl_opcode, o_pl_data}, 32'hFFFF_FFFF);
               end else begin
                  e_pl = exp_pl_q.pop_front();
                  check("pl_word", {11'd0, o_pl_last, o_pl_opcode, o_pl_data}, {11'd0, e_pl});
               end
            end
            if (o_frame_done) begin
               if (exp_sts_q.size() == 0) begin
                  check("sts_unexpected", {13'd0, o_frame_status, o_tx_data}, 32'hFFFF_FFFF);
               end else begin
                  e_st = exp_sts_q.pop_front();
                  check("sts_word", {13'd0, o_frame_status, o_tx_data}, {13'd0, e_st});
               end
            end
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [15:0] csum;
      int          wait_cnt;

      rst_n      = 1'b0;
      i_rx_data  = '0;
      i_rx_valid = 1'b0;
      i_rx_error = 1'b0;
      i_spi_cs_n = 1'b0;
      i_pl_ready = 1'b1;
      i_tx_ready = 1'b1;
      idle(3);
      check("rst_pl_valid", {31'd0, o_pl_valid}, 32'd0);
      check("rst_tx_valid", {31'd0, o_tx_valid}, 32'd0);
      check("rst_tx_data", {16'd0, o_tx_data}, 32'd0);
      check("rst_done", {31'd0, o_frame_done}, 32'd0);
      check("rst_level", {27'd0, o_fifo_level}, 32'd0);
      rst_n = 1'b1;
      idle(2);

      // Good frame: A532, 1111, 2222, checksum 9601
      exp_pl(1'b0, 4'h3, 16'h1111);
      exp_pl(1'b1, 4'h3, 16'h2222);
      exp_sts(3'd0, 16'h5A30);
      send_word(16'hA532);
      send_word(16'h1111);
      check("good_level_1", {27'd0, o_fifo_level}, 32'd1);
      send_word(16'h2222);
      check("good_level_2", {27'd0, o_fifo_level}, 32'd2);
      send_word(16'h9601);
      check("good_done_timing", {31'd0, o_frame_done}, 32'd1);
      check("good_tx_valid", {31'd0, o_tx_valid}, 32'd1);
      check("good_not_yet_valid", {31'd0, o_pl_valid}, 32'd0);
      idle(1);
      check("good_commit_latency", {31'd0, o_pl_valid}, 32'd1);
      check("good_tx_drop", {31'd0, o_tx_valid}, 32'd0);
      idle(4);
      check("good_level_drained", {27'd0, o_fifo_level}, 32'd0);

      // Bad checksum: payload must be rewound and never shown
      exp_sts(3'd2, 16'h5A32);
      send_word(16'hA532);
      send_word(16'h1111);
      send_word(16'h2222);
      check("bad_level_pre", {27'd0, o_fifo_level}, 32'd2);
      send_word(16'h0000);
      check("bad_level_rewind", {27'd0, o_fifo_level}, 32'd0);
      check("bad_tx_data", {16'd0, o_tx_data}, 32'h0000_5A32);
      idle(4);
      check("bad_no_payload", {31'd0, o_pl_valid}, 32'd0);

      // Overflow: 15 committed words held back, then a len-2 frame
      i_pl_ready = 1'b0;
      csum = 16'hA51F;
      for (int i = 0; i < 15; i++) begin
         exp_pl(i == 14, 4'h1, 16'h0100 + 16'(i));
         csum = csum ^ (16'h0100 + 16'(i));
      end
      exp_sts(3'd0, 16'h5A10);
      send_word(16'hA51F);
      for (int i = 0; i < 15; i++) send_word(16'h0100 + 16'(i));
      send_word(csum);
      idle(3);
      check("ovf_level_15", {27'd0, o_fifo_level}, 32'd15);
      check("ovf_held_valid", {31'd0, o_pl_valid}, 32'd1);
      check("ovf_held_data", {16'd0, o_pl_data}, 32'h0000_0100);
      exp_sts(3'd3, 16'h5A23);
      send_word(16'hA522);
      send_word(16'h7777);
      send_word(16'h8888);
      send_word(16'h9999);
      check("ovf_status", {29'd0, o_frame_status}, 32'd3);
      idle(2);
      check("ovf_level_kept", {27'd0, o_fifo_level}, 32'd15);
      check("ovf_data_stable", {16'd0, o_pl_data}, 32'h0000_0100);
      i_pl_ready = 1'b1;
      idle(20);
      check("ovf_level_drained", {27'd0, o_fifo_level}, 32'd0);

      // CS abort after 1 of 4 payload words, then a clean frame
      exp_sts(3'd4, 16'h5A44);
      send_word(16'hA544);
      send_word(16'hAAAA);
      check("abort_level_pre", {27'd0, o_fifo_level}, 32'd1);
      i_spi_cs_n = 1'b1;
      idle(1);
      check("abort_done", {31'd0, o_frame_done}, 32'd1);
      check("abort_level_rewind", {27'd0, o_fifo_level}, 32'd0);
      i_spi_cs_n = 1'b0;
      idle(1);
      exp_pl(1'b1, 4'h5, 16'hBEEF);
      exp_sts(3'd0, 16'h5A50);
      send_word(16'hA551);
      send_word(16'hBEEF);
      send_word(16'h1BBE);
      idle(5);

      // RX error mid-frame
      exp_sts(3'd6, 16'h5A66);
      send_word(16'hA562);
      send_word(16'h3333);
      i_rx_error = 1'b1;
      idle(1);
      i_rx_error = 1'b0;
      check("rxerr_level_rewind", {27'd0, o_fifo_level}, 32'd0);
      idle(2);

      // Bad sync, then zero-length frame, with the status side stalled
      i_tx_ready = 1'b0;
      exp_sts(3'd1, 16'h5A01);
      send_word(16'h1234);
      check("sync_tx_data", {16'd0, o_tx_data}, 32'h0000_5A01);
      idle(2);
      check("sync_tx_held", {31'd0, o_tx_valid}, 32'd1);
      exp_sts(3'd0, 16'h5A70);
      send_word(16'hA570);
      send_word(16'hA570);
      check("zero_tx_overwrite", {16'd0, o_tx_data}, 32'h0000_5A70);
      check("zero_tx_valid", {31'd0, o_tx_valid}, 32'd1);
      i_tx_ready = 1'b1;
      idle(1);
      check("zero_tx_drop", {31'd0, o_tx_valid}, 32'd0);
      idle(4);
      check("zero_no_payload", {31'd0, o_pl_valid}, 32'd0);

      // Drain: every expected entry must have been seen
      wait_cnt = 0;
      while ((exp_pl_q.size() != 0 || exp_sts_q.size() != 0) && wait_cnt < 100) begin
         idle(1);
         wait_cnt++;
      end
      check("pl_queue_empty", exp_pl_q.size(), 32'd0);
      check("sts_queue_empty", exp_sts_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
